// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx_fifo byte buffer and drain sequencer.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACT  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_fifo_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Circular byte FIFO: storage, pointers, occupancy count, sticky overflow.
// Full/empty come from the count register so pointer rollover needs no extra bit.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Rd_En,
  output logic [UART_BYTE_W-1:0] o_Rd_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic                   r_overflow;
  logic                   w_full;
  logic                   w_wr_ok;

  assign w_full  = (r_count == CNT_FULL);
  // A pop in the same cycle frees the slot, so a write at full is still accepted.
  assign w_wr_ok = i_Wr_DV & (~w_full | i_Rd_En);

  always_ff @(posedge i_Clock) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_Rd_En) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr_ok, i_Rd_En})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (i_Wr_DV && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_Rd_Byte  = r_mem[r_rd_ptr];
  assign o_Full     = w_full;
  assign o_Empty    = (r_count == '0);
  assign o_Count    = r_count;
  assign o_Overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain sequencer feeding uart_tx, paced on its Active/Done flags.
// Optional launch/drop statistics ports are enabled by defining UART_TX_FIFO_STATS_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_DV,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [ADDR_W:0]        o_Count,
  output logic                   o_Overflow,
  output logic                   o_Tx_DV,
  output logic [UART_BYTE_W-1:0] o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]            o_Tx_Cnt,
  output logic [7:0]             o_Drop_Cnt
`endif
);

  logic [UART_BYTE_W-1:0] w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  tx_fifo_state_t         r_state;
  tx_fifo_state_t         w_next_state;
  logic                   r_tx_dv;
  logic [UART_BYTE_W-1:0] r_tx_byte;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .i_Wr_DV    (i_Wr_DV),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Rd_En    (w_pop),
    .o_Rd_Byte  (w_head),
    .o_Full     (w_full),
    .o_Empty    (w_empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // IDLE re-checks Active so uart_tx's cleanup cycle (or a frame surviving our reset) is absorbed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty && !i_Tx_Active) begin
          w_next_state = LAUNCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      LAUNCH: begin
        w_next_state = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (i_Tx_Done) begin
          w_next_state = IDLE;
        end else if (i_Tx_Active) begin
          w_next_state = WAIT_DONE;
        end else begin
          w_next_state = WAIT_ACT;
        end
      end
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if ((r_state == IDLE) && (w_next_state == LAUNCH)) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_tx_dv <= w_pop;
      if (w_pop) begin
        r_tx_byte <= w_head;
      end
    end
  end

  assign o_Tx_DV   = r_tx_dv;
  assign o_Tx_Byte = r_tx_byte;
  assign o_Full    = w_full;
  assign o_Empty   = w_empty;

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] r_tx_cnt;
  logic [7:0]  r_drop_cnt;
  logic        w_drop;

  assign w_drop = i_Wr_DV & w_full & ~w_pop;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_cnt   <= 16'h0000;
      r_drop_cnt <= 8'h00;
    end else begin
      if (w_pop) begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc8(r_drop_cnt);
      end
    end
  end

  assign o_Tx_Cnt   = r_tx_cnt;
  assign o_Drop_Cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural uart_tx stand-in and a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int BOUND = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          u_rst_n;
  logic          wr_dv;
  logic [7:0]    wr_byte;
  logic          full, empty, ovf, tx_dv;
  logic [AW:0]   count;
  logic [7:0]    tx_byte;
  logic          u_active, tx_done, force_act, tx_active;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]   tx_cnt;
  logic [7:0]    drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] got[$];
  logic       m_busy   = 1'b0;
  logic       m_launch = 1'b0;
  logic       m_dv     = 1'b0;
  logic       m_ovf    = 1'b0;
  logic [7:0] m_byte   = 8'h00;
  int         m_drops    = 0;
  int         m_launches = 0;
  logic       prev_dv  = 1'b0;

  int u_st;
  int u_cnt;

  always #5 clk = ~clk;

  assign tx_active = u_active | force_act;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_Wr_DV     (wr_dv),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (ovf),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .o_Tx_Cnt    (tx_cnt),
    .o_Drop_Cnt  (drop_cnt)
`endif
  );

  // uart_tx stand-in: Active for one frame, then Done high for stop-end and cleanup cycles.
  always @(posedge clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      u_st     <= 0;
      u_cnt    <= 0;
      u_active <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      case (u_st)
        0: begin
          tx_done <= 1'b0;
          if (tx_dv) begin
            u_st     <= 1;
            u_cnt    <= 0;
            u_active <= 1'b1;
          end
        end
        1: begin
          if (u_cnt == FRAME - 1) begin
            u_st     <= 2;
            u_active <= 1'b0;
            tx_done  <= 1'b1;
          end else begin
            u_cnt <= u_cnt + 1;
          end
        end
        default: begin
          tx_done <= 1'b1;
          u_st    <= 0;
        end
      endcase
    end
  end

  // Per-cycle scoreboard against the reference model, plus launch-protocol rules.
  always @(posedge clk) begin
    #1;
    checks++;
    if (tx_dv !== m_dv) begin failures++; $display("FAIL mon_tx_dv got=%b exp=%b t=%0t", tx_dv, m_dv, $time); end
    checks++;
    if (tx_byte !== m_byte) begin failures++; $display("FAIL mon_tx_byte got=%h exp=%h t=%0t", tx_byte, m_byte, $time); end
    checks++;
    if (count !== (AW+1)'(m_q.size())) begin failures++; $display("FAIL mon_count got=%0d exp=%0d t=%0t", count, m_q.size(), $time); end
    checks++;
    if (full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin
      failures++; $display("FAIL mon_flags full=%b empty=%b exp_size=%0d t=%0t", full, empty, m_q.size(), $time);
    end
    checks++;
    if (ovf !== m_ovf) begin failures++; $display("FAIL mon_overflow got=%b exp=%b t=%0t", ovf, m_ovf, $time); end
    if (tx_dv === 1'b1) begin
      checks++;
      if (prev_dv || tx_active) begin
        failures++; $display("FAIL mon_launch_rule prev_dv=%b active=%b exp=0/0 t=%0t", prev_dv, tx_active, $time);
      end
      got.push_back(tx_byte);
    end
    prev_dv = tx_dv;
  end

  task automatic model_clear();
    m_q.delete();
    m_busy = 1'b0; m_launch = 1'b0; m_dv = 1'b0; m_ovf = 1'b0; m_byte = 8'h00;
    m_drops = 0; m_launches = 0;
  endtask

  // Drive one cycle (called at a falling edge) and advance the model by the spec's rules.
  task automatic step(input logic wr, input logic [7:0] b);
    logic pop, acc;
    wr_dv = wr;
    wr_byte = b;
    if (rst_n) begin
      pop = !m_busy && (m_q.size() != 0) && !(u_active | force_act);
      acc = wr && ((m_q.size() < DEPTH) || pop);
      if (pop) begin
        m_byte = m_q.pop_front();
        m_sent.push_back(m_byte);
        m_busy = 1'b1; m_launch = 1'b1; m_launches++;
      end else if (m_launch) begin
        m_launch = 1'b0;
      end else if (m_busy && tx_done) begin
        m_busy = 1'b0;
      end
      if (acc) m_q.push_back(b);
      else if (wr) begin m_ovf = 1'b1; if (m_drops < 255) m_drops++; end
      m_dv = pop;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((m_q.size() != 0 || m_busy || u_st != 0 || u_active || tx_done) && n < BOUND) begin
      step(1'b0, 8'h00);
      n++;
    end
    ok = (n < BOUND);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (count !== '0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
    checks++; if (tx_dv !== 1'b0)  begin failures++; $display("FAIL reset_tx_dv got=%b exp=0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (tx_cnt !== 16'h0000 || drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_stats tx=%0d drop=%0d exp=0/0", tx_cnt, drop_cnt); end
`endif
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    step(1'b0, 8'h00);
  endtask

  task automatic test_single();
    bit ok;
    got.delete(); m_sent.delete();
    step(1'b1, 8'hAB);
    checks++; if (count !== (AW+1)'(1) || tx_dv !== 1'b0) begin failures++; $display("FAIL single_write count=%0d dv=%b exp=1/0", count, tx_dv); end
    step(1'b0, 8'h00);
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'hAB) begin failures++; $display("FAIL single_launch dv=%b byte=%h exp=1/ab", tx_dv, tx_byte); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
    step(1'b0, 8'h00);
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL single_dv_width got=%b exp=0", tx_dv); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain timeout exp=idle"); end
    checks++; if (got.size() != 1 || got[0] !== 8'hAB) begin failures++; $display("FAIL single_rx n=%0d exp=1 byte ab", got.size()); end
  endtask

  task automatic test_burst();
    bit ok;
    int peak = 0;
    got.delete(); m_sent.delete();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(i));
      if (int'(count) > peak) peak = int'(count);
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_drain timeout exp=idle"); end
    checks++; if (peak != 4 && peak != 5) begin failures++; $display("FAIL burst_peak got=%0d exp=4or5", peak); end
    checks++; if (ovf !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL burst_end ovf=%b empty=%b exp=0/1", ovf, empty); end
    checks++;
    if (got.size() != 5) begin failures++; $display("FAIL burst_rx_len got=%0d exp=5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== 8'(i + 1)) begin failures++; $display("FAIL burst_rx[%0d] got=%h exp=%h", i, got[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    got.delete(); m_sent.delete();
    force_act = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h10 + 8'(i));
      if (i == 3) begin
        checks++; if (full !== 1'b1 || count !== (AW+1)'(4) || ovf !== 1'b0) begin failures++; $display("FAIL ovf_full full=%b count=%0d ovf=%b exp=1/4/0", full, count, ovf); end
      end
    end
    checks++; if (ovf !== 1'b1 || count !== (AW+1)'(4)) begin failures++; $display("FAIL ovf_set ovf=%b count=%0d exp=1/4", ovf, count); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
`endif
    force_act = 1'b0;
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_drain timeout exp=idle"); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL ovf_rx_len got=%0d exp=4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovf_rx[%0d] got=%h exp=%h", i, got[i], 8'h10 + 8'(i)); end
    end
    apply_reset();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_simul_full();
    bit ok;
    got.delete(); m_sent.delete();
    force_act = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i));
    force_act = 1'b0;
    step(1'b1, 8'h34);
    checks++; if (count !== (AW+1)'(4) || ovf !== 1'b0) begin failures++; $display("FAIL simul_count count=%0d ovf=%b exp=4/0", count, ovf); end
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h30) begin failures++; $display("FAIL simul_launch dv=%b byte=%h exp=1/30", tx_dv, tx_byte); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL simul_drain timeout exp=idle"); end
    checks++;
    if (got.size() != 5) begin failures++; $display("FAIL simul_rx_len got=%0d exp=5", got.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (got[i] !== 8'h30 + 8'(i)) begin failures++; $display("FAIL simul_rx[%0d] got=%h exp=%h", i, got[i], 8'h30 + 8'(i)); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    got.delete(); m_sent.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h20 + 8'(i));
      repeat ($urandom_range(FRAME, FRAME + 20)) step(1'b0, 8'h00);
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain timeout exp=idle"); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL wrap_overflow got=%b exp=0", ovf); end
    checks++;
    if (got.size() != 10) begin failures++; $display("FAIL wrap_rx_len got=%0d exp=10", got.size()); end
    else for (int i = 0; i < 10; i++) begin
      checks++; if (got[i] !== 8'h20 + 8'(i)) begin failures++; $display("FAIL wrap_rx[%0d] got=%h exp=%h", i, got[i], 8'h20 + 8'(i)); end
    end
  endtask

  task automatic test_random();
    bit ok;
    apply_reset();
    got.delete(); m_sent.delete();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 19) == 0) force_act = ~force_act;
      step(($urandom_range(0, 2) == 0), 8'($urandom));
    end
    force_act = 1'b0;
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_drain timeout exp=idle"); end
    checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rand_overflow got=%b exp=%b", ovf, m_ovf); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (tx_cnt !== 16'(m_launches)) begin failures++; $display("FAIL rand_tx_cnt got=%0d exp=%0d", tx_cnt, m_launches); end
    checks++; if (drop_cnt !== 8'(m_drops)) begin failures++; $display("FAIL rand_drop_cnt got=%0d exp=%0d", drop_cnt, m_drops); end
`endif
    checks++;
    if (got.size() != m_sent.size()) begin failures++; $display("FAIL rand_rx_len got=%0d exp=%0d", got.size(), m_sent.size()); end
    else for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== m_sent[i]) begin failures++; $display("FAIL rand_rx[%0d] got=%h exp=%h", i, got[i], m_sent[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw = 1'b0;
    int n = 0;
    got.delete(); m_sent.delete();
    step(1'b1, 8'h3F);
    step(1'b1, 8'hA1);
    step(1'b1, 8'hA2);
    while (!(u_st == 1 && u_cnt == 4 * CPB + CPB / 2) && n < 500) begin step(1'b0, 8'h00); n++; end
    checks++; if (n >= 500 || count !== (AW+1)'(2)) begin failures++; $display("FAIL mid_setup wait=%0d count=%0d exp=<500/2", n, count); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_reset_fifo count=%0d empty=%b full=%b exp=0/1/0", count, empty, full); end
    checks++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin failures++; $display("FAIL mid_reset_tx dv=%b byte=%h exp=0/00", tx_dv, tx_byte); end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    step(1'b1, 8'h55);
    n = 0;
    while (!saw && n < 500) begin
      step(1'b0, 8'h00);
      n++;
      if (tx_dv === 1'b1) begin
        saw = 1'b1;
        checks++; if (u_st != 0 || tx_byte !== 8'h55) begin failures++; $display("FAIL mid_relaunch uart_state=%0d byte=%h exp=0/55", u_st, tx_byte); end
      end
    end
    checks++; if (!saw) begin failures++; $display("FAIL mid_no_launch waited=%0d exp=launch", n); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_drain timeout exp=idle"); end
    checks++; if (got.size() != 2 || got[0] !== 8'h3F || got[1] !== 8'h55) begin failures++; $display("FAIL mid_rx n=%0d exp=2 bytes 3f,55", got.size()); end
  endtask

  initial begin
    rst_n = 1'b0; u_rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00; force_act = 1'b0;
    @(negedge clk);
    @(negedge clk);
    u_rst_n = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul_full();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and transmit sequencer placed directly upstream of uart_tx.
- Accepts bursts of bytes from the host side at clock rate, stores them in a circular FIFO, and drains them one at a time into uart_tx.
- Drives uart_tx's i_Tx_DV/i_Tx_Byte and paces itself on uart_tx's o_Tx_Active/o_Tx_Done, so back-to-back bytes go out with no host polling.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Rst_L  input  1  asynchronous reset, active-low.
- i_Wr_DV  input  1  one-cycle write strobe from host.
- i_Wr_Byte  input  8  byte to enqueue; sampled when i_Wr_DV=1.
- o_Full  output  1  FIFO holds DEPTH bytes.
- o_Empty  output  1  FIFO holds 0 bytes.
- o_Count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Overflow  output  1  sticky; set when a write is dropped while full.
- o_Tx_DV  output  1  one-cycle launch strobe to uart_tx i_Tx_DV.
- o_Tx_Byte  output  8  byte to uart_tx i_Tx_Byte; held stable from launch until the next launch.
- i_Tx_Active  input  1  from uart_tx o_Tx_Active.
- i_Tx_Done  input  1  from uart_tx o_Tx_Done.

Behaviour:
- Clocking and reset: one clock, i_Clock; reset is asynchronous and active-low, i_Rst_L.
- Reset values: read/write pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Overflow 0, o_Tx_DV 0, o_Tx_Byte 8'h00, FSM in IDLE. The storage array is not reset.
- Write:
  - i_Wr_DV=1 and not full: store at wr_ptr; wr_ptr increments modulo DEPTH; count increments. The new data is visible to the drain FSM on the next cycle.
- Write while full:
  - Byte is discarded; pointers and count are unchanged; o_Overflow sets to 1.
  - o_Overflow clears only on reset.
- Pop:
  - Occurs only in the IDLE->LAUNCH transition. The head byte is registered into o_Tx_Byte; rd_ptr increments modulo DEPTH; count decrements.
  - A simultaneous write and pop leaves count unchanged. This includes a write when count=DEPTH on the pop cycle: the write is accepted and there is no overflow.
- Pointer wrap: natural ADDR_W-bit rollover; full/empty are derived from the count register, not from pointer compare.
- FSM states:
  - IDLE: if count>0 and i_Tx_Active=0, go to LAUNCH (pop).
  - LAUNCH: o_Tx_DV=1 for exactly this one cycle; go to WAIT_ACT.
  - WAIT_ACT: wait for i_Tx_Active=1, then go to WAIT_DONE. If i_Tx_Done=1 is seen first, go directly to IDLE.
  - WAIT_DONE: on i_Tx_Done=1 go to IDLE.
- Pacing: IDLE re-checks i_Tx_Active=0 before every launch, which absorbs uart_tx's cleanup cycle.
  - Launch latency from the first write into an empty FIFO with uart_tx idle: o_Tx_DV is high 2 cycles after the i_Wr_DV cycle.
- Reset mid-transfer:
  - The FIFO empties and the FSM returns to IDLE. uart_tx is not reset and may still be active.
  - The IDLE gating on i_Tx_Active prevents a launch until uart_tx finishes its frame.
- o_Tx_DV is never asserted on two consecutive cycles, and never while i_Tx_Active=1.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- When defined:
  - Adds output o_Tx_Cnt [15:0]: count of launches since reset, wrapping at 16'hFFFF to 0.
  - Adds output o_Drop_Cnt [7:0]: count of dropped writes, saturating at 8'hFF.
  - Both reset to 0.
- When undefined: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACT, WAIT_DONE} tx_fifo_state_t.
  - localparam UART_BYTE_W = 8.
- Sub-module byte_fifo (DEPTH param): storage, pointers, count, full/empty, overflow.
- uart_tx_fifo instantiates byte_fifo and holds the drain FSM.

Test Plan:
- Single byte: write 8'hAB into an empty FIFO with uart_tx (CLKS_PER_BIT=87) attached -> o_Tx_DV pulses 2 cycles later with o_Tx_Byte=8'hAB; serial line carries start, bits of 0xAB LSB-first, stop; o_Empty=1 after the pop.
- Burst: write 8'h01..8'h05 on consecutive cycles -> five o_Tx_DV pulses, in order, each after i_Tx_Done with i_Tx_Active low; o_Count peaks at 4 or 5 and returns to 0.
- Full/overflow, DEPTH=4: hold uart_tx busy, write 6 bytes 8'h10..8'h15 -> o_Full=1 at count 4; o_Overflow=1; only 8'h10..8'h13 are transmitted; with STATS_EN, o_Drop_Cnt=2.
- Simultaneous write and pop at count=DEPTH -> o_Count stays DEPTH; o_Overflow stays 0; byte is later transmitted in order.
- Wrap: DEPTH=4; stream 10 bytes 8'h20..8'h29 with gaps -> all received in order across two pointer wraps.
- Reset mid-frame: assert i_Rst_L=0 during bit 3 of 8'h3F with 2 bytes queued -> outputs return to reset values immediately; after release, write 8'h55 -> no o_Tx_DV until i_Tx_Active falls, then 8'h55 is sent intact.
